// File: rtl/touch_pwm_ctrl.sv
// Two-button touch controller: in_1 cycles the selected PWM channel, in_2 steps
// its duty. Raw inputs are synchronised and debounced before edge detection.
module touch_pwm_ctrl #(
  parameter int CH      = 3,
  parameter int PWM_W   = 8,
  parameter int STEP    = 32,
  parameter int DEB_CNT = 48000,
  localparam int SEL_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_1,
  input  logic                  in_2,
  output logic [CH-1:0]         pwm_o,
  output logic [SEL_W-1:0]      sel_o,
  output logic [CH*PWM_W-1:0]   duty_o
);

  localparam int DC_W = $clog2(DEB_CNT);

  // Index 0 carries in_1 (channel select), index 1 carries in_2 (duty step).
  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          deb_q, deb_d;
  logic [1:0]          deb_prev_q, deb_prev_d;
  logic [DC_W-1:0]     dcnt_q [2];
  logic [DC_W-1:0]     dcnt_d [2];
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CH*PWM_W-1:0] duty_q, duty_d;
  logic [PWM_W-1:0]    cnt_q, cnt_d;
  logic [CH-1:0]       pwm_q, pwm_d;
  logic [1:0]          press;
  logic [PWM_W-1:0]    cur_duty;
  logic [PWM_W:0]      sum;

  always_comb begin
    sync1_d    = {in_2, in_1};
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DC_W'(DEB_CNT - 1)) deb_d[i] = sync2_q[i];
        else dcnt_d[i] = dcnt_q[i] + DC_W'(1);
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  // Duty step uses the pre-advance selection when both presses coincide.
  always_comb begin
    sel_d    = sel_q;
    duty_d   = duty_q;
    cur_duty = '0;
    for (int c = 0; c < CH; c++) begin
      if (sel_q == SEL_W'(c)) cur_duty = duty_q[c*PWM_W +: PWM_W];
    end
    sum = {1'b0, cur_duty} + (PWM_W + 1)'(STEP);
    for (int c = 0; c < CH; c++) begin
      if (press[1] && (sel_q == SEL_W'(c)))
        duty_d[c*PWM_W +: PWM_W] = sum[PWM_W] ? '0 : sum[PWM_W-1:0];
    end
    if (press[0]) sel_d = (sel_q == SEL_W'(CH - 1)) ? '0 : sel_q + SEL_W'(1);
  end

  always_comb begin
    cnt_d = cnt_q + PWM_W'(1);
    pwm_d = '0;
    for (int c = 0; c < CH; c++) begin
      pwm_d[c] = cnt_q < duty_q[c*PWM_W +: PWM_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      dcnt_q[0]  <= '0;
      dcnt_q[1]  <= '0;
      sel_q      <= '0;
      duty_q     <= '0;
      cnt_q      <= '0;
      pwm_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      dcnt_q[0]  <= dcnt_d[0];
      dcnt_q[1]  <= dcnt_d[1];
      sel_q      <= sel_d;
      duty_q     <= duty_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign sel_o  = sel_q;
  assign duty_o = duty_q;

endmodule
